// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder: FSM states, default word width
// and the bit-counter width helper.
package serial_word_feeder_pkg;

  // Default word width, kept in step with the downstream serial complementer.
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter width able to index every bit of a word; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_word_feeder_if.sv
// Parallel-in handshake plus serial-out stream of the word feeder.
// The producer/consumer side uses master; the feeder uses slave.
interface serial_word_feeder_if #(
  parameter int WIDTH = serial_word_feeder_pkg::DEFAULT_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_bit;
  logic             ser_valid;
  logic             set;
  logic             ser_last;
  logic             busy;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_bit, ser_valid, set, ser_last, busy
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_bit, ser_valid, set, ser_last, busy
  );

endinterface

// File: rtl/serial_word_feeder_hold.sv
// One-entry hold register that parks a word while the shifter is mid-word.
// Its full flag alone decides whether the feeder can accept another word.
module serial_word_feeder_hold
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_ready
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  // NOTE: the data register is reset too, so no stale word survives reset;
  // only r_full is strictly needed for correctness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_push) begin
      // A push in the same edge as a pop refills the entry, so it stays full.
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_full  = r_full;
  assign o_ready = !r_full;

endmodule

// File: rtl/serial_word_feeder.sv
// Parallel-to-serial feeder: accepts words over valid/ready and emits them one bit
// per cycle with set on the first bit and ser_last on the final bit.
module serial_word_feeder
  import serial_word_feeder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_word_feeder_if.slave bus
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic             r_ser_bit, r_ser_valid, r_set, r_ser_last;

  logic             w_ready, w_hold_full, w_xfer, w_free;
  logic             w_hold_push, w_hold_pop, w_load, w_advance;
  logic [WIDTH-1:0] w_hold_data, w_load_word, w_load_rest, w_shift_rest;
  logic             w_first_bit, w_next_bit;

  assign w_xfer      = bus.in_valid && w_ready;
  // The shifter can take a new word when idle or while showing a word's last bit.
  assign w_free      = (r_state == IDLE) || (r_cnt == LAST);
  assign w_hold_push = w_xfer && (!w_free || w_hold_full);
  assign w_hold_pop  = w_free && w_hold_full;

  serial_word_feeder_hold #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_hold_push),
    .i_pop   (w_hold_pop),
    .i_data  (bus.in_data),
    .o_data  (w_hold_data),
    .o_full  (w_hold_full),
    .o_ready (w_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_load_word  = bus.in_data;
    if (w_free) begin
      if (w_hold_full) begin
        w_load      = 1'b1;
        w_load_word = w_hold_data;
      end else if (w_xfer) begin
        w_load = 1'b1;
      end
      w_state_next = w_load ? SHIFT : IDLE;
    end else begin
      w_advance = 1'b1;
    end
  end

  assign w_first_bit  = MSB_FIRST ? w_load_word[WIDTH-1] : w_load_word[0];
  assign w_load_rest  = MSB_FIRST ? (w_load_word << 1) : (w_load_word >> 1);
  assign w_next_bit   = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shift_rest = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);

  // r_cnt is the index of the bit currently on ser_bit; r_shreg holds the rest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_shreg     <= '0;
      r_ser_bit   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_set       <= 1'b0;
      r_ser_last  <= 1'b0;
    end else if (w_load) begin
      r_cnt       <= '0;
      r_shreg     <= w_load_rest;
      r_ser_bit   <= w_first_bit;
      r_ser_valid <= 1'b1;
      r_set       <= 1'b1;
      r_ser_last  <= 1'b0;
    end else if (w_advance) begin
      r_cnt       <= r_cnt + CW'(1);
      r_shreg     <= w_shift_rest;
      r_ser_bit   <= w_next_bit;
      r_ser_valid <= 1'b1;
      r_set       <= 1'b0;
      r_ser_last  <= ((r_cnt + CW'(1)) == LAST);
    end else begin
      r_cnt       <= '0;
      r_ser_bit   <= 1'b0;
      r_ser_valid <= 1'b0;
      r_set       <= 1'b0;
      r_ser_last  <= 1'b0;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.ser_bit   = r_ser_bit;
  assign bus.ser_valid = r_ser_valid;
  assign bus.set       = r_set;
  assign bus.ser_last  = r_ser_last;
  assign bus.busy      = (r_state == SHIFT) || w_hold_full;

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench for serial_word_feeder: LSB-first and MSB-first instances share one stimulus;
// directed tables and sequences first, then random traffic against a word-queue model.
module tb_serial_word_feeder;
  import serial_word_feeder_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         tb_valid;
  logic [W-1:0] tb_data;

  always #5 clk = ~clk;

  serial_word_feeder_if #(.WIDTH(W)) bus_l ();
  serial_word_feeder_if #(.WIDTH(W)) bus_m ();

  assign bus_l.in_valid = tb_valid;
  assign bus_l.in_data  = tb_data;
  assign bus_m.in_valid = tb_valid;
  assign bus_m.in_data  = tb_data;

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  serial_word_feeder #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_m)
  );

  // Observed outputs packed as {ser_valid, set, ser_last, ser_bit, in_ready, busy}.
  logic [5:0] obs_l, obs_m;
  assign obs_l = {bus_l.ser_valid, bus_l.set, bus_l.ser_last, bus_l.ser_bit,
                  bus_l.in_ready, bus_l.busy};
  assign obs_m = {bus_m.ser_valid, bus_m.set, bus_m.ser_last, bus_m.ser_bit,
                  bus_m.in_ready, bus_m.busy};

  localparam logic [5:0] IDLE_OUT = 6'b000010;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (valid,set,last,bit,ready,busy)", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         valid;
    logic [W-1:0] data;
    logic [5:0]   exp;
  } vec_t;

  vec_t vecs[14];

  // Reference model: words accepted but not fully emitted, plus position in the head word.
  logic [W-1:0] word_q[$];
  int           bit_pos;
  logic         exp_ready;

  initial begin
    tb_valid = 1'b0;
    tb_data  = '0;

    // Single word 1010, then 1010/0011 back to back with extra offers while held.
    vecs[0]  = '{1'b1, 4'b1010, 6'b110011};
    vecs[1]  = '{1'b0, 4'b0000, 6'b100111};
    vecs[2]  = '{1'b0, 4'b0000, 6'b100011};
    vecs[3]  = '{1'b0, 4'b0000, 6'b101111};
    vecs[4]  = '{1'b0, 4'b0000, 6'b000010};
    vecs[5]  = '{1'b1, 4'b1010, 6'b110011};
    vecs[6]  = '{1'b1, 4'b0011, 6'b100101};
    vecs[7]  = '{1'b1, 4'b1111, 6'b100001};
    vecs[8]  = '{1'b1, 4'b1111, 6'b101101};
    vecs[9]  = '{1'b0, 4'b0000, 6'b110111};
    vecs[10] = '{1'b0, 4'b0000, 6'b100111};
    vecs[11] = '{1'b0, 4'b0000, 6'b100011};
    vecs[12] = '{1'b0, 4'b0000, 6'b101011};
    vecs[13] = '{1'b0, 4'b0000, 6'b000010};

    // Reset state while asserted and just after release.
    #12;
    check("reset_lsb", obs_l, IDLE_OUT);
    check("reset_msb", obs_m, IDLE_OUT);
    step();
    rst_n = 1'b1;
    step();
    check("post_reset_lsb", obs_l, IDLE_OUT);
    check("post_reset_msb", obs_m, IDLE_OUT);

    for (int i = 0; i < 14; i++) begin
      tb_valid = vecs[i].valid;
      tb_data  = vecs[i].data;
      step();
      check($sformatf("table[%0d]", i), obs_l, vecs[i].exp);
    end

    // MSB-first 1000 against LSB-first of the same word.
    tb_valid = 1'b1; tb_data = 4'b1000;
    step();
    check("msb_bit0", obs_m, 6'b110111);
    check("lsb_bit0", obs_l, 6'b110011);
    tb_valid = 1'b0;
    step();
    check("msb_bit1", obs_m, 6'b100011);
    check("lsb_bit1", obs_l, 6'b100011);
    step();
    check("msb_bit2", obs_m, 6'b100011);
    check("lsb_bit2", obs_l, 6'b100011);
    step();
    check("msb_bit3", obs_m, 6'b101011);
    check("lsb_bit3", obs_l, 6'b101111);
    step();
    check("msb_idle", obs_m, IDLE_OUT);

    // Reset mid-word with a second word held.
    tb_valid = 1'b1; tb_data = 4'b1111;
    step();
    check("rst_mid_bit0", obs_l, 6'b110111);
    tb_data = 4'b0101;
    step();
    check("rst_mid_bit1", obs_l, 6'b100101);
    tb_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", obs_l, IDLE_OUT);
    check("rst_mid_async_msb", obs_m, IDLE_OUT);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_quiet[%0d]", i), obs_l, IDLE_OUT);
    end
    tb_valid = 1'b1; tb_data = 4'b0110;
    step();
    check("after_rst_bit0", obs_l, 6'b110011);
    tb_valid = 1'b0;
    step();
    check("after_rst_bit1", obs_l, 6'b100111);
    step();
    check("after_rst_bit2", obs_l, 6'b100111);
    step();
    check("after_rst_bit3", obs_l, 6'b101011);
    step();
    check("after_rst_idle", obs_l, IDLE_OUT);

    // Random traffic against the word-queue model; the last cycles drain the stream.
    word_q.delete();
    bit_pos   = 0;
    exp_ready = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      logic         xfer;
      logic [W-1:0] word, head;
      int           remaining;
      logic [5:0]   exp_l, exp_m;

      tb_valid = (cyc < 588) && ($urandom_range(0, 3) != 0);
      tb_data  = W'($urandom);
      xfer     = tb_valid && exp_ready;
      word     = tb_data;
      step();
      if (xfer) word_q.push_back(word);

      remaining = word_q.size() * W - bit_pos;
      exp_ready = (remaining <= W);
      exp_l = {5'b00000, remaining > 0};
      exp_l[1] = exp_ready;
      exp_m = exp_l;
      if (remaining > 0) begin
        head  = word_q[0];
        exp_l[5:2] = {1'b1, bit_pos == 0, bit_pos == W - 1, head[bit_pos]};
        exp_m[5:2] = {1'b1, bit_pos == 0, bit_pos == W - 1, head[W - 1 - bit_pos]};
      end
      check($sformatf("rand_lsb[%0d]", cyc), obs_l, exp_l);
      check($sformatf("rand_msb[%0d]", cyc), obs_m, exp_m);

      if (remaining > 0) begin
        bit_pos++;
        if (bit_pos == W) begin
          void'(word_q.pop_front());
          bit_pos = 0;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
